branch_resolve_ctrl: RTL and testbench

- D-stage branch resolution controller for the pipelined MIPS core.
- Accepts a decoded conditional branch and waits, stalling the front end, until the operands it needs are forwarded-valid.
- Evaluates the 12-code branch condition set, then issues one registered resolve pulse carrying the taken flag and target PC.
- Keeps branch and taken counters for the perf/debug bus.

---
 rtl/branch_resolve_ctrl.sv | 129 ++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: D-stage conditional branch resolver with operand-wait stall and perf counters
// Ports:
//   clk, reset (async, active-low)
//   br_valid, br_op, pc_d, imm16       decoded branch in D
//   rs_val, rt_val, rs_ready, rt_ready forwarded operands and their readiness
//   kill                               synchronous flush, highest priority
//   stall_d                            freeze F/D (combinational)
//   resolve_valid, taken, target_pc    one-cycle resolve pulse with held result
//   hazard_err                         sticky wait-timeout / illegal-op flag
//   br_count, taken_count              resolved / resolved-taken counters
module branch_resolve_ctrl #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             br_valid,
    input  logic [3:0]       br_op,
    input  logic [31:0]      pc_d,
    input  logic [15:0]      imm16,
    input  logic [31:0]      rs_val,
    input  logic [31:0]      rt_val,
    input  logic             rs_ready,
    input  logic             rt_ready,
    input  logic             kill,
    output logic             stall_d,
    output logic             resolve_valid,
    output logic             taken,
    output logic [31:0]      target_pc,
    output logic             hazard_err,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] taken_count
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam logic [7:0] WMAX = 8'(WAIT_MAX);
    state_t      state;
    logic [3:0]  op_q;
    logic [31:0] pc_q;
    logic [15:0] imm_q;
    logic [7:0]  wcnt;
    logic [7:0]  wcnt_n;
    logic [3:0]  op;
    logic [3:0]  sel;
    logic [31:0] src_pc;
    logic [15:0] src_imm;
    logic [31:0] b;
    logic [31:0] tgt;
    logic        idle;
    logic        need_rt;
    logic        illegal;
    logic        rdy;
    logic        eq;
    logic        gt;
    logic        lt;
    logic        cond;
    // In IDLE the branch is evaluated straight from the D-stage inputs so a
    // ready branch resolves next cycle; in WAIT the captured copy is used.
    assign idle    = state == IDLE;
    assign op      = idle ? br_op : op_q;
    assign src_pc  = idle ? pc_d : pc_q;
    assign src_imm = idle ? imm16 : imm_q;
    assign illegal = op >= 4'd12;
    assign need_rt = op <= 4'd5;
    // Illegal codes need no operands: they resolve at once as not taken.
    assign rdy     = illegal | (rs_ready & (rt_ready | ~need_rt));
    assign b       = need_rt ? rt_val : 32'd0;
    assign eq      = rs_val == b;
    assign gt      = $signed(rs_val) > $signed(b);
    assign lt      = $signed(rs_val) < $signed(b);
    // Codes 6-11 are the zero-compare twins of 0-5 in the same order.
    assign sel     = need_rt ? op : op - 4'd6;
    assign cond    = illegal ? 1'b0 :
                     sel == 4'd0 ? eq :
                     sel == 4'd1 ? gt :
                     sel == 4'd2 ? lt :
                     sel == 4'd3 ? ~eq :
                     sel == 4'd4 ? ~lt : ~gt;
    assign tgt     = src_pc + 32'd4 + {{14{src_imm[15]}}, src_imm, 2'b00};
    assign wcnt_n  = wcnt == WMAX ? wcnt : wcnt + 8'd1;
    assign resolve_valid = (state == RESP) & ~kill;
    assign stall_d = reset & ~kill & ((idle & br_valid) | (state == WAIT));
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            op_q        <= '0;
            pc_q        <= '0;
            imm_q       <= '0;
            wcnt        <= '0;
            taken       <= 1'b0;
            target_pc   <= '0;
            hazard_err  <= 1'b0;
            br_count    <= '0;
            taken_count <= '0;
        end else if (kill) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (br_valid) begin
                    op_q  <= br_op;
                    pc_q  <= pc_d;
                    imm_q <= imm16;
                    wcnt  <= '0;
                    if (illegal) hazard_err <= 1'b1;
                    if (rdy) begin
                        taken     <= cond;
                        target_pc <= tgt;
                        state     <= RESP;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: if (rdy) begin
                    taken     <= cond;
                    target_pc <= tgt;
                    state     <= RESP;
                end else begin
                    wcnt <= wcnt_n;
                    if (wcnt_n == WMAX) hazard_err <= 1'b1;
                end
                RESP: begin
                    br_count    <= br_count + 1'b1;
                    taken_count <= taken_count + CNT_W'(taken);
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: directed self-checking bench for branch_resolve_ctrl
module tb_branch_resolve_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        br_valid = 1'b0;
    logic [3:0]  br_op = '0;
    logic [31:0] pc_d = '0;
    logic [15:0] imm16 = '0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        rs_ready = 1'b0;
    logic        rt_ready = 1'b0;
    logic        kill = 1'b0;
    logic        stall_d;
    logic        resolve_valid;
    logic        taken;
    logic [31:0] target_pc;
    logic        hazard_err;
    logic [31:0] br_count;
    logic [31:0] taken_count;
    int ncmp = 0;
    int nfail = 0;

    branch_resolve_ctrl #(.WAIT_MAX(15), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .br_valid(br_valid), .br_op(br_op),
        .pc_d(pc_d), .imm16(imm16), .rs_val(rs_val), .rt_val(rt_val),
        .rs_ready(rs_ready), .rt_ready(rt_ready), .kill(kill),
        .stall_d(stall_d), .resolve_valid(resolve_valid), .taken(taken),
        .target_pc(target_pc), .hazard_err(hazard_err),
        .br_count(br_count), .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] pc, input logic [15:0] imm,
                         input logic exp_tk, input logic [31:0] exp_tgt);
        br_valid = 1'b1; br_op = op; rs_val = rs; rt_val = rt;
        rs_ready = 1'b1; rt_ready = 1'b1; pc_d = pc; imm16 = imm;
        #1;
        chk({tag, "_stall"}, 32'(stall_d), 32'd1);
        tick();
        br_valid = 1'b0;
        #1;
        chk({tag, "_rv"}, 32'(resolve_valid), 32'd1);
        chk({tag, "_taken"}, 32'(taken), 32'(exp_tk));
        chk({tag, "_tgt"}, target_pc, exp_tgt);
        chk({tag, "_stall_resp"}, 32'(stall_d), 32'd0);
        tick();
        chk({tag, "_rv_off"}, 32'(resolve_valid), 32'd0);
    endtask

    initial begin
        #12;
        chk("rst_stall", 32'(stall_d), 32'd0);
        chk("rst_rv", 32'(resolve_valid), 32'd0);
        chk("rst_tgt", target_pc, 32'd0);
        chk("rst_cnt", br_count, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        issue("eq_ready", 4'd0, 32'h5, 32'h5, 32'h3000, 16'h0004, 1'b1, 32'h3014);
        chk("eq_brcnt", br_count, 32'd1);
        chk("eq_tkcnt", taken_count, 32'd1);
        chk("eq_hold", 32'(taken), 32'd1);

        issue("lt_signed", 4'd2, 32'hFFFFFFFF, 32'h1, 32'h100, 16'h0, 1'b1, 32'h104);
        issue("ltz_zero", 4'd8, 32'h0, 32'h0, 32'h100, 16'h0, 1'b0, 32'h104);
        issue("lez_zero", 4'd11, 32'h0, 32'h0, 32'h100, 16'h0, 1'b1, 32'h104);
        issue("gt_neg", 4'd1, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h100, 16'h0, 1'b1, 32'h104);
        issue("ge_less", 4'd4, 32'h3, 32'h4, 32'h100, 16'h0, 1'b0, 32'h104);
        issue("gtz_min", 4'd7, 32'h80000000, 32'h0, 32'h100, 16'h0, 1'b0, 32'h104);
        issue("le_equal", 4'd5, 32'h5, 32'h5, 32'h100, 16'h0, 1'b1, 32'h104);
        issue("gez_zero", 4'd10, 32'h0, 32'h0, 32'h100, 16'h0, 1'b1, 32'h104);
        issue("eq_diff", 4'd0, 32'h1, 32'h2, 32'h100, 16'h0, 1'b0, 32'h104);
        chk("sgn_brcnt", br_count, 32'd10);
        chk("sgn_tkcnt", taken_count, 32'd6);

        // NE with rt pending for 3 cycles; backward offset -1 word
        br_valid = 1'b1; br_op = 4'd3; rs_val = 32'h7; rs_ready = 1'b1;
        rt_ready = 1'b0; rt_val = 32'h0; pc_d = 32'h1000; imm16 = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("wait_stall", 32'(stall_d), 32'd1);
            chk("wait_rv", 32'(resolve_valid), 32'd0);
            tick();
        end
        rt_ready = 1'b1; rt_val = 32'h7;
        #1;
        chk("wait_stall_rdy", 32'(stall_d), 32'd1);
        tick();
        br_valid = 1'b0;
        #1;
        chk("wait_rv_pulse", 32'(resolve_valid), 32'd1);
        chk("wait_taken", 32'(taken), 32'd0);
        chk("wait_tgt", target_pc, 32'h1000);
        chk("wait_haz", 32'(hazard_err), 32'd0);
        tick();
        chk("wait_brcnt", br_count, 32'd11);
        chk("wait_tkcnt", taken_count, 32'd6);

        // Timeout: EQZ with rs not ready
        br_valid = 1'b1; br_op = 4'd6; rs_ready = 1'b0; rt_ready = 1'b0;
        pc_d = 32'h200; imm16 = 16'h0010;
        tick();
        repeat (14) tick();
        chk("to_haz_pre", 32'(hazard_err), 32'd0);
        tick();
        chk("to_haz_set", 32'(hazard_err), 32'd1);
        chk("to_stall", 32'(stall_d), 32'd1);
        rs_ready = 1'b1; rs_val = 32'h0;
        tick();
        br_valid = 1'b0;
        #1;
        chk("to_rv", 32'(resolve_valid), 32'd1);
        chk("to_taken", 32'(taken), 32'd1);
        chk("to_tgt", target_pc, 32'h244);
        tick();
        chk("to_haz_sticky", 32'(hazard_err), 32'd1);
        chk("to_brcnt", br_count, 32'd12);
        chk("to_tkcnt", taken_count, 32'd7);

        // Kill while waiting
        br_valid = 1'b1; br_op = 4'd0; rs_ready = 1'b1; rt_ready = 1'b0;
        tick();
        kill = 1'b1;
        #1;
        chk("killw_stall", 32'(stall_d), 32'd0);
        tick();
        kill = 1'b0; br_valid = 1'b0;
        #1;
        chk("killw_rv", 32'(resolve_valid), 32'd0);
        chk("killw_stall_after", 32'(stall_d), 32'd0);
        tick();
        chk("killw_rv2", 32'(resolve_valid), 32'd0);

        // Kill in the resolve cycle
        br_valid = 1'b1; br_op = 4'd0; rs_val = 32'h1; rt_val = 32'h1;
        rs_ready = 1'b1; rt_ready = 1'b1;
        tick();
        br_valid = 1'b0; kill = 1'b1;
        #1;
        chk("killr_rv", 32'(resolve_valid), 32'd0);
        chk("killr_stall", 32'(stall_d), 32'd0);
        tick();
        kill = 1'b0;
        #1;
        chk("killr_rv_after", 32'(resolve_valid), 32'd0);
        chk("killr_brcnt", br_count, 32'd12);
        chk("killr_tkcnt", taken_count, 32'd7);
        chk("killr_haz", 32'(hazard_err), 32'd1);

        issue("wrap", 4'd9, 32'h1, 32'h0, 32'hFFFFFFF8, 16'h0002, 1'b1, 32'h00000004);
        chk("wrap_brcnt", br_count, 32'd13);
        chk("wrap_tkcnt", taken_count, 32'd8);

        // Async reset in the middle of a wait
        br_valid = 1'b1; br_op = 4'd0; rs_ready = 1'b1; rt_ready = 1'b0;
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("arst_stall", 32'(stall_d), 32'd0);
        chk("arst_haz", 32'(hazard_err), 32'd0);
        chk("arst_taken", 32'(taken), 32'd0);
        chk("arst_tgt", target_pc, 32'd0);
        chk("arst_brcnt", br_count, 32'd0);
        chk("arst_tkcnt", taken_count, 32'd0);
        @(negedge clk);
        br_valid = 1'b0;
        reset = 1'b1;

        issue("illegal", 4'd13, 32'h5, 32'h5, 32'h400, 16'h0001, 1'b0, 32'h408);
        chk("ill_haz", 32'(hazard_err), 32'd1);
        chk("ill_brcnt", br_count, 32'd1);
        chk("ill_tkcnt", taken_count, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
